tdc_timestamp_fifo: RTL and testbench

- Sits directly downstream of the fine-TDC-plus-encoder stage.
- Pairs each encoded fine value with a free-running coarse clock count to form a full timestamp word. It also inserts coarse-rollover (epoch) marker words.
- Buffers both word types in a show-ahead FIFO with a valid/ready readout port, so readout logic can drain at its own pace.
- Overflow losses are counted, not silent.

---
 rtl/tdc_timestamp_fifo.sv | 148 ++++++++++++++
 tb/tb_tdc_timestamp_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_timestamp_fifo.sv
// tdc_timestamp_fifo
//   Builds timestamp words from encoded fine values and a latency-compensated
//   coarse counter, inserts epoch marker words on every coarse rollover, and
//   buffers everything in a show-ahead FIFO with a valid/ready readout port.
//
// Ports
//   clock       : system clock, rising edge
//   reset       : asynchronous, active-high, clears all state
//   enable      : when low, new strobes and markers are discarded
//   hit_strobe  : one-cycle pulse, fine_value valid in the same cycle
//   fine_value  : encoded fine time
//   out_data    : head word {type, coarse/epoch, fine}; 0 when out_valid = 0
//   out_valid   : out_data holds a word
//   out_ready   : consumer accepts the head word when out_valid && out_ready
//   fill_level  : number of words held in the FIFO
//   drop_count  : words lost, saturating at 0xFFFF
module tdc_timestamp_fifo #(
  parameter int FINE_BITS   = 8,
  parameter int COARSE_BITS = 16,
  parameter int LATENCY     = 4,
  parameter int DEPTH       = 16,
  localparam int W          = 1 + COARSE_BITS + FINE_BITS,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 hit_strobe,
  input  logic [FINE_BITS-1:0] fine_value,
  output logic [W-1:0]         out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AW:0]          fill_level,
  output logic [15:0]          drop_count
);

  // Stamp counter starts LATENCY counts below zero so that a hit strobed at
  // cycle k carries the coarse time at which it was sampled upstream.
  localparam logic [COARSE_BITS-1:0] STAMP_RST =
    COARSE_BITS'((1 << COARSE_BITS) - LATENCY);

  logic [COARSE_BITS-1:0] stamp_q;
  logic [W-2:0]           epoch_q;
  logic                   wrap;

  logic                   skid_valid_q, skid_valid_d;
  logic [W-1:0]           skid_word_q, skid_word_d;

  logic [W-1:0]           mem [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            count_q;
  logic [15:0]            drop_q;

  logic                   mark, hit;
  logic [W-1:0]           marker_word, hit_word;
  logic                   wr_req, do_write, pop, full, lost;
  logic [W-1:0]           wr_word;
  logic [1:0]             drop_inc;
  logic [16:0]            drop_sum;

  // Stamp value zero is the first cycle of a new epoch.
  assign wrap        = (stamp_q == '0);
  assign mark        = enable && wrap;
  assign hit         = enable && hit_strobe;
  assign marker_word = {1'b1, epoch_q + 1'b1};
  assign hit_word    = {1'b0, stamp_q, fine_value};

  // One write slot per cycle: marker, then skid word, then the new hit.
  always_comb begin
    wr_req       = 1'b0;
    wr_word      = '0;
    skid_valid_d = skid_valid_q;
    skid_word_d  = skid_word_q;
    lost         = 1'b0;
    if (mark) begin
      wr_req  = 1'b1;
      wr_word = marker_word;
      if (hit) begin
        if (skid_valid_q) begin
          // Marker and a still-pending skid word leave no room for a third
          // word; it is lost and counted rather than reordered.
          lost = 1'b1;
        end else begin
          skid_valid_d = 1'b1;
          skid_word_d  = hit_word;
        end
      end
    end else if (skid_valid_q) begin
      wr_req  = 1'b1;
      wr_word = skid_word_q;
      if (hit) begin
        skid_word_d = hit_word;
      end else begin
        skid_valid_d = 1'b0;
      end
    end else if (hit) begin
      wr_req  = 1'b1;
      wr_word = hit_word;
    end
  end

  assign pop      = out_valid && out_ready;
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign do_write = wr_req && (!full || pop);
  assign drop_inc = 2'(wr_req && !do_write) + 2'(lost);
  assign drop_sum = {1'b0, drop_q} + 17'(drop_inc);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stamp_q      <= STAMP_RST;
      epoch_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_word_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_q       <= '0;
    end else begin
      stamp_q      <= stamp_q + 1'b1;
      if (wrap) begin
        epoch_q <= epoch_q + 1'b1;
      end
      skid_valid_q <= skid_valid_d;
      skid_word_q  <= skid_word_d;
      if (do_write) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + (AW+1)'(do_write) - (AW+1)'(pop);
      drop_q  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (do_write) begin
      mem[wr_ptr_q] <= wr_word;
    end
  end

  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? mem[rd_ptr_q] : '0;
  assign fill_level = count_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_tdc_timestamp_fifo.sv
// tb_tdc_timestamp_fifo
//   Self-checking bench for tdc_timestamp_fifo. A reference model keeps an
//   ordered list of generated-but-unwritten words and the FIFO contents as
//   queues; every cycle the DUT outputs are compared against it, alongside
//   directed checks on the key stamp, epoch, overflow and reset scenarios.
module tb_tdc_timestamp_fifo;
  localparam int FB = 8;
  localparam int CB = 16;
  localparam int LAT = 4;
  localparam int D = 16;
  localparam int W = 1 + CB + FB;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          hit_strobe = 1'b0;
  logic [FB-1:0] fine_value = '0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic [4:0]    fill_level;
  logic [15:0]   drop_count;

  tdc_timestamp_fifo #(
    .FINE_BITS  (FB),
    .COARSE_BITS(CB),
    .LATENCY    (LAT),
    .DEPTH      (D)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .hit_strobe(hit_strobe),
    .fine_value(fine_value),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill_level(fill_level),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;
  int kl = -1;
  logic [W-1:0] fifo_m[$];
  logic [W-1:0] pend_m[$];
  int unsigned  epoch_m = 0;
  int unsigned  drops_m = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, kl);
    end
  endtask

  // Reference behaviour of one rising edge, from the current inputs.
  task automatic model_edge();
    logic [CB-1:0] st;
    logic [W-1:0]  w;
    st = CB'(k - LAT);
    if (st == '0) epoch_m++;
    if (fifo_m.size() > 0 && out_ready) void'(fifo_m.pop_front());
    if (enable && st == '0) pend_m.push_back({1'b1, 24'(epoch_m)});
    if (enable && hit_strobe) pend_m.push_back({1'b0, st, fine_value});
    if (pend_m.size() > 0) begin
      w = pend_m.pop_front();
      if (fifo_m.size() < D) fifo_m.push_back(w);
      else if (drops_m < 16'hFFFF) drops_m++;
    end
  endtask

  task automatic compare_model();
    check("valid", 64'(out_valid), 64'(fifo_m.size() > 0));
    check("fill", 64'(fill_level), 64'(fifo_m.size()));
    check("drops", 64'(drop_count), 64'(drops_m));
    if (fifo_m.size() > 0) check("data", 64'(out_data), 64'(fifo_m[0]));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    kl = k;
    k++;
    compare_model();
  endtask

  task automatic set_in(input logic en, input logic stb, input logic [FB-1:0] fv, input logic rdy);
    enable = en;
    hit_strobe = stb;
    fine_value = fv;
    out_ready = rdy;
  endtask

  // Asserts reset between edges, checks that outputs clear without a clock,
  // then releases it so that the following edge is k = 0.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_fill", 64'(fill_level), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    fifo_m.delete();
    pend_m.delete();
    epoch_m = 0;
    drops_m = 0;
    k = 0;
    kl = -1;
    @(posedge clock);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    int pops;
    int nstb;
    int gap;
    int guard;
    logic         hold;
    logic [W-1:0] held;

    async_reset();

    // Basic stamp, epoch wrap and simultaneous marker/hit
    while (k <= 65543) begin
      case (k)
        100:     set_in(1'b1, 1'b1, 8'h5A, 1'b1);
        65539:   set_in(1'b1, 1'b1, 8'h11, 1'b1);
        65540:   set_in(1'b1, 1'b1, 8'h22, 1'b1);
        65541:   set_in(1'b1, 1'b1, 8'h33, 1'b1);
        default: set_in(1'b1, 1'b0, 8'h00, 1'b1);
      endcase
      step();
      case (kl)
        3:     check("pre_marker_valid", 64'(out_valid), 64'd0);
        4: begin
          check("marker1_valid", 64'(out_valid), 64'd1);
          check("marker1_data", 64'(out_data), 64'({1'b1, 24'd1}));
        end
        5:     check("marker1_popped", 64'(out_valid), 64'd0);
        100: begin
          check("hit96_valid", 64'(out_valid), 64'd1);
          check("hit96_data", 64'(out_data), 64'({1'b0, 16'd96, 8'h5A}));
        end
        101:   check("hit96_once", 64'(out_valid), 64'd0);
        65539: check("hitFFFF_data", 64'(out_data), 64'({1'b0, 16'hFFFF, 8'h11}));
        65540: check("marker2_data", 64'(out_data), 64'({1'b1, 24'd2}));
        65541: check("hit22_data", 64'(out_data), 64'({1'b0, 16'd0, 8'h22}));
        65542: check("hit33_data", 64'(out_data), 64'({1'b0, 16'd1, 8'h33}));
        65543: check("wrap_drained", 64'(out_valid), 64'd0);
        default: ;
      endcase
    end
    check("wrap_no_drop", 64'(drop_count), 64'd0);

    // Overflow: marker at k=4 plus 16 strobes with the consumer stalled
    async_reset();
    while (k <= 30) begin
      set_in(1'b1, (k >= 10 && k <= 25), 8'(k * 7), 1'b0);
      step();
    end
    check("ovf_fill", 64'(fill_level), 64'd16);
    check("ovf_drop", 64'(drop_count), 64'd1);
    pops = 0;
    for (int i = 0; i < 40; i++) begin
      set_in(1'b1, 1'b0, 8'h00, 1'b1);
      if (out_valid) pops++;
      step();
    end
    check("ovf_drained", 64'(pops), 64'd16);
    check("ovf_empty", 64'(fill_level), 64'd0);

    // Fill to 5 then reset asynchronously mid-stream
    for (int i = 0; i < 12; i++) begin
      set_in(1'b1, (i % 2 == 0 && i < 10), 8'(i + 1), 1'b0);
      step();
    end
    check("pre_rst_fill", 64'(fill_level), 64'd5);
    async_reset();
    while (k <= 4) begin
      set_in(1'b1, 1'b0, 8'h00, 1'b1);
      step();
      check("post_rst_marker_valid", 64'(out_valid), 64'(kl == 4));
    end
    check("post_rst_marker_data", 64'(out_data), 64'({1'b1, 24'd1}));

    // Backpressure with random ready, enable and strobe spacing
    nstb = 0;
    gap = 3;
    guard = 0;
    while (nstb < 1000 && guard < 8000) begin
      guard++;
      out_ready = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 7) != 0);
      if (gap == 0) begin
        hit_strobe = 1'b1;
        fine_value = 8'($urandom);
        gap = $urandom_range(2, 5);
        nstb++;
      end else begin
        hit_strobe = 1'b0;
        gap--;
      end
      hold = out_valid && !out_ready;
      held = out_data;
      step();
      if (hold) check("stable", 64'(out_data), 64'(held));
    end
    check("bp_strobes", 64'(nstb), 64'd1000);
    for (int i = 0; i < 24; i++) begin
      set_in(1'b1, 1'b0, 8'h00, 1'b1);
      step();
    end
    check("bp_empty", 64'(fill_level), 64'd0);
    check("bp_no_drop", 64'(drop_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
